// File: rtl/instr_issue_queue.sv
// Instruction issue queue: FIFO-buffered host instructions issued one at a time to the array,
// with a completion handshake and watchdog. Optional macro OPCODE_FILTER_EN drops NOP pushes.
module instr_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    input  logic                     array_busy,
    input  logic                     array_done,
    output logic [31:0]              issue_instr,
    output logic                     start,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    // Fires on the edge where the watchdog would reach TIMEOUT cycles since start
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [WW-1:0] wdog;
    logic          full;
    logic          empty;
    logic          is_nop;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = ~full;

`ifdef OPCODE_FILTER_EN
    assign is_nop = (in_instr[31:26] == 6'b000000);
`else
    assign is_nop = 1'b0;
`endif

    assign push = in_valid & in_ready & ~flush & ~is_nop;
    assign pop  = (state == S_IDLE) & ~empty & ~array_busy & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= S_IDLE;
            start       <= 1'b0;
            issue_instr <= '0;
            timeout_err <= 1'b0;
            wdog        <= '0;
        end else if (flush) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= S_IDLE;
            start       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        issue_instr <= mem[rd_ptr];
                        start       <= 1'b1;
                        wdog        <= '0;
                        state       <= S_WAIT;
                    end else begin
                        start <= 1'b0;
                    end
                end
                S_WAIT: begin
                    start <= 1'b0;
                    if (array_done) begin
                        state <= S_IDLE;
                    end else if (wdog == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                default: begin
                    start <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OPCODE_FILTER_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (in_valid && in_ready && !flush && is_nop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: stimulus queues expected issue words, a monitor
// compares them whenever start pulses. Build with OPCODE_FILTER_EN to also cover NOP dropping.
module tb_instr_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        array_busy;
    logic        array_done;
    logic [31:0] issue_instr;
    logic        start;
    logic [3:0]  count;
    logic        timeout_err;
    logic [7:0]  drop_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];

    instr_issue_queue #(.DEPTH(8), .TIMEOUT(1023)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .array_busy(array_busy),
        .array_done(array_done),
        .issue_instr(issue_instr),
        .start(start),
        .count(count),
        .timeout_err(timeout_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every start pulse must match the oldest word the stimulus expects to issue
    always @(negedge clk) begin
        if (reset === 1'b1 && start === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_start: got %h expected no issue at %0t", issue_instr, $time);
            end else begin
                check("issue_order", issue_instr, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(name, {31'd0, start}, 32'd1);
    endtask

    task automatic pulse_done();
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [31:0] w;
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        array_busy = 1'b0;
        array_done = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_issue", issue_instr, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);

        // T2: single-word latency and one-cycle start
        exp_q.push_back(32'h08241800);
        push_word(32'h08241800);
        check("t2_start_k", {31'd0, start}, 32'd0);
        check("t2_count_k", {28'd0, count}, 32'd1);
        tick();
        check("t2_start_k1", {31'd0, start}, 32'd1);
        check("t2_issue", issue_instr, 32'h08241800);
        tick();
        check("t2_start_k2", {31'd0, start}, 32'd0);
        repeat (2) tick();
        pulse_done();

        // T3: fill while busy, overflow ignored, drain in order
        array_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 32'h1000_0000 + 32'(i * 17);
            exp_q.push_back(w);
            push_word(w);
        end
        check("t3_full_count", {28'd0, count}, 32'd8);
        check("t3_full_ready", {31'd0, in_ready}, 32'd0);
        push_word(32'hDEAD_BEEF);
        check("t3_overflow_count", {28'd0, count}, 32'd8);
        check("t3_busy_nostart", {31'd0, start}, 32'd0);
        array_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_start("t3_issue_seen");
            pulse_done();
        end
        check("t3_drained", {28'd0, count}, 32'd0);

        // T4: watchdog fires TIMEOUT cycles after start, then next head issues
        exp_q.push_back(32'h0C00_00A1);
        exp_q.push_back(32'h0C00_00B2);
        push_word(32'h0C00_00A1);
        push_word(32'h0C00_00B2);
        wait_start("t4_first_start");
        repeat (1022) tick();
        check("t4_terr_early", {31'd0, timeout_err}, 32'd0);
        check("t4_nostart_early", {31'd0, start}, 32'd0);
        tick();
        check("t4_terr_fire", {31'd0, timeout_err}, 32'd1);
        tick();
        check("t4_next_start", {31'd0, start}, 32'd1);
        check("t4_next_issue", issue_instr, 32'h0C00_00B2);
        pulse_done();
        check("t4_terr_sticky", {31'd0, timeout_err}, 32'd1);

        // T5: flush beats same-cycle push and issue
        array_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(32'h2000_0000 + 32'(i));
        end
        check("t5_count5", {28'd0, count}, 32'd5);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'h3333_3333;
        array_busy = 1'b0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_count0", {28'd0, count}, 32'd0);
        check("t5_terr0", {31'd0, timeout_err}, 32'd0);
        check("t5_nostart", {31'd0, start}, 32'd0);
        check("t5_issue_kept", issue_instr, 32'h0C00_00B2);
        tick();
        check("t5_nostart2", {31'd0, start}, 32'd0);
        check("t5_still_empty", {28'd0, count}, 32'd0);

        // T1: reset in the middle of WAIT with a word still queued
        exp_q.push_back(32'h0800_0111);
        push_word(32'h0800_0111);
        push_word(32'h0800_0222);
        check("t1_inwait_count", {28'd0, count}, 32'd1);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t1_start", {31'd0, start}, 32'd0);
        check("t1_count", {28'd0, count}, 32'd0);
        check("t1_terr", {31'd0, timeout_err}, 32'd0);
        check("t1_issue", issue_instr, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("t1_no_reissue", {31'd0, start}, 32'd0);

`ifdef OPCODE_FILTER_EN
        // T6: NOP accepted but dropped
        exp_q.push_back(32'h08241800);
        push_word(32'h0000_0000);
        push_word(32'h08241800);
        check("t6_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        wait_start("t6_start");
        check("t6_issue", issue_instr, 32'h08241800);
        pulse_done();
`else
        push_word(32'h0000_0000);
        check("t6_nofilter_drop", {24'd0, drop_cnt}, 32'd0);
        exp_q.push_back(32'h0000_0000);
        wait_start("t6_nop_issues");
        pulse_done();
`endif

        repeat (4) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
